// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver.
// Frame: start(0), 8 data bits LSB first, parity, stop(1).
// Optional feature macro UART_RX_OVERRUN_EN: adds rx_ack/overrun and makes
// rx_valid a level that is held until acknowledged.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int OVS       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       p_sel,
`ifdef UART_RX_OVERRUN_EN
  input  logic       rx_ack,
  output logic       overrun,
`endif
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVS);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_bad_q, par_bad_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
`ifdef UART_RX_OVERRUN_EN
  logic              overrun_q, overrun_d;
`endif
  logic              rx_s;
  logic              tick;
  logic              frame_done;

  assign rx_s       = sync_q[1];
  assign tick       = (tick_cnt_q == TICK_MAX);
  assign busy       = (state_q != S_IDLE);
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
`ifdef UART_RX_OVERRUN_EN
  assign overrun    = overrun_q;
`endif

  // Two-flop synchronizer input and free-running oversample tick divider.
  always_comb begin
    sync_d     = {sync_q[0], rx_in};
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Frame FSM: every decision is taken on an oversample tick using rx_s.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    frame_done   = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            cnt_d   = 4'd0;
          end
        end
        S_START: begin
          // Mid-bit check rejects glitches shorter than half a bit.
          if (cnt_q == 4'd7) begin
            cnt_d     = 4'd0;
            bit_idx_d = 3'd0;
            state_d   = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == 4'd15) begin
            shift_d   = {rx_s, shift_q[7:1]};
            cnt_d     = 4'd0;
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_PARITY: begin
          if (cnt_q == 4'd15) begin
            par_bad_d = (^shift_q) ^ rx_s ^ p_sel;
            cnt_d     = 4'd0;
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == 4'd15) begin
            frame_done   = 1'b1;
            rx_data_d    = shift_q;
            parity_err_d = par_bad_q;
            frame_err_d  = ~rx_s;
            cnt_d        = 4'd0;
            state_d      = rx_s ? S_IDLE : S_BREAK;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_BREAK: begin
          // Wait for the line to return high before hunting for a new start.
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Valid/overrun handshake toward the parallel side.
  always_comb begin
`ifdef UART_RX_OVERRUN_EN
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (frame_done) begin
      // A completion beats a simultaneous acknowledge.
      rx_valid_d = 1'b1;
      if (!rx_ack) overrun_d = overrun_q | rx_valid_q;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
`else
    rx_valid_d = frame_done;
`endif
  end

  // State register; reset wins over everything, synchronizer idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      tick_cnt_q   <= '0;
      cnt_q        <= 4'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      par_bad_q    <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
      overrun_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      tick_cnt_q   <= tick_cnt_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_OVERRUN_EN
      overrun_q    <= overrun_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx (DIV=10, one bit = 160 clk).
module tb_uart_rx;

  localparam int CLK_FREQ  = 1600000;
  localparam int BAUD_RATE = 10000;
  localparam int BIT_CLKS  = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       p_sel;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_OVERRUN_EN
  logic       rx_ack;
  logic       overrun;
`endif

  int vecs = 0;
  int miscompares = 0;
  int valid_cnt = 0;
  int pre;
  logic prev_v = 1'b0;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVS(16)) dut (
    .clk(clk),
    .reset(reset),
    .rx_in(rx_in),
    .p_sel(p_sel),
`ifdef UART_RX_OVERRUN_EN
    .rx_ack(rx_ack),
    .overrun(overrun),
`endif
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Count valid cycles (pulse build) or valid rising edges (level build).
  always @(posedge clk) begin
`ifdef UART_RX_OVERRUN_EN
    if (rx_valid && !prev_v) valid_cnt <= valid_cnt + 1;
`else
    if (rx_valid) valid_cnt <= valid_cnt + 1;
`endif
    prev_v <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    idle(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stp);
  endtask

  task automatic ack();
`ifdef UART_RX_OVERRUN_EN
    rx_ack = 1'b1;
    idle(1);
    rx_ack = 1'b0;
`endif
    idle(1);
  endtask

  initial begin
    reset = 1'b1;
    rx_in = 1'b1;
    p_sel = 1'b0;
`ifdef UART_RX_OVERRUN_EN
    rx_ack = 1'b0;
`endif
    idle(5);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    idle(20);

    // 0xA5 (four ones), even parity, parity bit 0
    pre = valid_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(20);
    check("a5_valid_count", 32'(valid_cnt - pre), 32'd1);
    check("a5_rx_data", 32'(rx_data), 32'hA5);
    check("a5_parity_err", 32'(parity_err), 32'h0);
    check("a5_frame_err", 32'(frame_err), 32'h0);
    check("a5_busy", 32'(busy), 32'h0);
    ack();

    // 0x07 (three ones), odd parity: parity bit 1 is wrong, 0 is right
    p_sel = 1'b1;
    pre = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("07bad_valid_count", 32'(valid_cnt - pre), 32'd1);
    check("07bad_rx_data", 32'(rx_data), 32'h07);
    check("07bad_parity_err", 32'(parity_err), 32'h1);
    check("07bad_frame_err", 32'(frame_err), 32'h0);
    ack();
    send_frame(8'h07, 1'b0, 1'b1);
    idle(20);
    check("07ok_rx_data", 32'(rx_data), 32'h07);
    check("07ok_parity_err", 32'(parity_err), 32'h0);
    ack();
    p_sel = 1'b0;

    // 0x3C with stop bit 0, line held low into BREAK
    pre = valid_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_in = 1'b0;
    idle(4 * BIT_CLKS);
    check("brk_busy_low_line", 32'(busy), 32'h1);
    check("brk_rx_data", 32'(rx_data), 32'h3C);
    check("brk_frame_err", 32'(frame_err), 32'h1);
    check("brk_parity_err", 32'(parity_err), 32'h0);
    rx_in = 1'b1;
    idle(2 * BIT_CLKS);
    check("brk_busy_after", 32'(busy), 32'h0);
    check("brk_valid_count", 32'(valid_cnt - pre), 32'd1);
    ack();

    // 30-clk low glitch on an idle line
    pre = valid_cnt;
    rx_in = 1'b0;
    idle(25);
    check("glitch_busy_start", 32'(busy), 32'h1);
    idle(5);
    rx_in = 1'b1;
    idle(130);
    check("glitch_busy_after", 32'(busy), 32'h0);
    check("glitch_valid_count", 32'(valid_cnt - pre), 32'd0);
    check("glitch_data_hold", 32'(rx_data), 32'h3C);
    check("glitch_frame_err_hold", 32'(frame_err), 32'h1);

    // Reset pulse in data bit 4; the line is left high afterwards
    pre = valid_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx_in = 1'b1;
    idle(80);
    check("abort_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("abort_busy_after_rst", 32'(busy), 32'h0);
    check("abort_rx_data_cleared", 32'(rx_data), 32'h00);
    check("abort_frame_err_cleared", 32'(frame_err), 32'h0);
    idle(7 * BIT_CLKS);
    check("abort_valid_count", 32'(valid_cnt - pre), 32'd0);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(20);
    check("81_valid_count", 32'(valid_cnt - pre), 32'd1);
    check("81_rx_data", 32'(rx_data), 32'h81);
    check("81_parity_err", 32'(parity_err), 32'h0);
    check("81_frame_err", 32'(frame_err), 32'h0);
    ack();

`ifdef UART_RX_OVERRUN_EN
    // Two back-to-back frames without acknowledge
    send_frame(8'h11, 1'b0, 1'b1);
    check("ovr_first_valid", 32'(rx_valid), 32'h1);
    check("ovr_first_overrun", 32'(overrun), 32'h0);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(5);
    check("ovr_rx_data", 32'(rx_data), 32'h22);
    check("ovr_overrun", 32'(overrun), 32'h1);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    rx_ack = 1'b1;
    idle(1);
    rx_ack = 1'b0;
    check("ovr_ack_valid", 32'(rx_valid), 32'h0);
    check("ovr_ack_overrun", 32'(overrun), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
